agc_sequencer: RTL

Multi-cycle control sequencer for the AGC datapath. It owns the program counter. It steps each instruction through fetch, decode and 1–3 execute cycles, and drives every mux select, write enable and ALU op of the register/ALU/memory datapath. It supports the eight Block I basic opcodes (TC, CCS, INDEX, XCH, CS, TS, AD, MASK).

---
 rtl/agc_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/agc_sequencer.sv
// AGC control sequencer: owns pc, steps each instruction FETCH/[IDX]/DECODE/EX1..EX3 and drives all datapath controls.
// 3-5 cycles per instruction (+1 when indexed); halt_req stalls in HALT at instruction boundaries. Option: AGC_SEQ_INDEX_EN.
module agc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] b_word,
  input  logic        x_sign,
  input  logic        x_zero,
  input  logic        halt_req,
  output logic [11:0] pc_addr,
  output logic [2:0]  alu_op,
  output logic [1:0]  MAddr_MUX,
  output logic [1:0]  A_MUX,
  output logic [1:0]  X_MUX,
  output logic [1:0]  Y_MUX,
  output logic [1:0]  Z_MUX,
  output logic [1:0]  Q_MUX,
  output logic        LP_MUX,
  output logic        B_MUX,
  output logic        LP_WE,
  output logic        G_WE,
  output logic        Q_WE,
  output logic        B_WE,
  output logic        A_WE,
  output logic        Y_WE,
  output logic        X_WE,
  output logic        Z_WE,
  output logic        mem_WE,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [2:0] {RST, FETCH, IDX, DECODE, EX1, EX2, EX3, HALT} state_t;

  localparam logic [2:0] OP_TC    = 3'd0;
  localparam logic [2:0] OP_CCS   = 3'd1;
  localparam logic [2:0] OP_INDEX = 3'd2;
  localparam logic [2:0] OP_XCH   = 3'd3;
  localparam logic [2:0] OP_CS    = 3'd4;
  localparam logic [2:0] OP_TS    = 3'd5;
  localparam logic [2:0] OP_AD    = 3'd6;
  localparam logic [2:0] OP_MASK  = 3'd7;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;

  localparam logic [1:0] MA_PC = 2'd0;
  localparam logic [1:0] MA_S  = 2'd1;

  state_t      state, nextState;
  logic [11:0] pc;
  logic [2:0]  opcode;
  logic        indexPending;
  logic        lastEx;
  logic        unusedParity;

  assign unusedParity = b_word[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RST;
      pc     <= 12'd0;
      opcode <= OP_TC;
    end else begin
      state <= nextState;
      if (state == DECODE) begin
        opcode <= b_word[15:13];
        pc     <= pc + 12'd1;
      end else if (state == EX1 && opcode == OP_TC) begin
        pc <= b_word[12:1];
      end else if (state == EX2 && opcode == OP_CCS) begin
        // skip encodes >0, +0, <0, -0 as 0..3
        pc <= pc + {10'd0, x_sign, x_zero};
      end
    end
  end

`ifdef AGC_SEQ_INDEX_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      indexPending <= 1'b0;
    end else if (state == EX1 && opcode == OP_INDEX) begin
      indexPending <= 1'b1;
    end else if (state == IDX) begin
      indexPending <= 1'b0;
    end
  end
`else
  assign indexPending = 1'b0;
`endif

  always_comb begin
    nextState  = state;
    pc_addr    = pc;
    alu_op     = ALU_ADD;
    MAddr_MUX  = MA_PC;
    A_MUX      = 2'd0;
    X_MUX      = 2'd0;
    Y_MUX      = 2'd0;
    Z_MUX      = 2'd0;
    Q_MUX      = 2'd0;
    LP_MUX     = 1'b0;
    B_MUX      = 1'b0;
    LP_WE      = 1'b0;
    G_WE       = 1'b0;
    Q_WE       = 1'b0;
    B_WE       = 1'b0;
    A_WE       = 1'b0;
    Y_WE       = 1'b0;
    X_WE       = 1'b0;
    Z_WE       = 1'b0;
    mem_WE     = 1'b0;
    lastEx     = 1'b0;
    unique case (state)
      RST:    nextState = FETCH;
      FETCH: begin
        B_WE = 1'b1;
        if (indexPending) begin
          // load X from Z and Y from memory so IDX can add the index into B
          X_WE      = 1'b1;
          X_MUX     = 2'd1;
          Y_WE      = 1'b1;
          nextState = IDX;
        end else begin
          nextState = DECODE;
        end
      end
      IDX: begin
        B_WE      = 1'b1;
        B_MUX     = 1'b1;
        nextState = DECODE;
      end
      DECODE: nextState = EX1;
      EX1: begin
        nextState = EX2;
        case (opcode)
          OP_TC:  lastEx = 1'b1;
          OP_CCS: begin
            MAddr_MUX = MA_S;
            X_WE      = 1'b1;
            Y_WE      = 1'b1;
            Y_MUX     = 2'd2;
          end
          OP_INDEX: begin
`ifdef AGC_SEQ_INDEX_EN
            MAddr_MUX = MA_S;
            Z_WE      = 1'b1;
`endif
            lastEx = 1'b1;
          end
          OP_XCH: begin
            MAddr_MUX = MA_S;
            G_WE      = 1'b1;
          end
          OP_CS: begin
            MAddr_MUX = MA_S;
            A_WE      = 1'b1;
          end
          OP_TS: begin
            MAddr_MUX = MA_S;
            mem_WE    = 1'b1;
            lastEx    = 1'b1;
          end
          default: begin
            MAddr_MUX = MA_S;
            X_WE      = 1'b1;
            Y_WE      = 1'b1;
            Y_MUX     = 2'd1;
          end
        endcase
      end
      EX2: begin
        nextState = EX3;
        case (opcode)
          OP_CCS: begin
            alu_op = ALU_SUB;
            A_WE   = 1'b1;
            A_MUX  = 2'd1;
            lastEx = 1'b1;
          end
          OP_XCH: begin
            MAddr_MUX = MA_S;
            mem_WE    = 1'b1;
          end
          OP_CS: begin
            A_WE   = 1'b1;
            A_MUX  = 2'd2;
            lastEx = 1'b1;
          end
          OP_AD: begin
            alu_op = ALU_ADD;
            A_WE   = 1'b1;
            A_MUX  = 2'd1;
            lastEx = 1'b1;
          end
          OP_MASK: begin
            alu_op = ALU_AND;
            A_WE   = 1'b1;
            A_MUX  = 2'd1;
            lastEx = 1'b1;
          end
          default: lastEx = 1'b1;
        endcase
      end
      EX3: begin
        A_WE   = 1'b1;
        A_MUX  = 2'd3;
        lastEx = 1'b1;
      end
      HALT:    nextState = halt_req ? HALT : FETCH;
      default: nextState = RST;
    endcase
    if (lastEx) nextState = halt_req ? HALT : FETCH;
    instr_done = lastEx;
    halted     = (state == HALT);
  end

endmodule
